// File: rtl/ins_fetch.sv
// Instruction fetch stage: keeps one fetch in flight against a fixed-latency
// memory and buffers the responses in a small FIFO for the decoder.
module ins_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_pc_o,
  input  logic [31:0] imem_pc_i,
  input  logic [31:0] imem_instr_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        dec_valid_o,
  input  logic        dec_ready_i,
  output logic [31:0] dec_pc_o,
  output logic [31:0] dec_instr_o,
  output logic        tag_err_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [31:0] pc_q, pc_d;
  logic [31:0] exp_pc_q, exp_pc_d;
  logic        inflight_q, inflight_d;
  logic        tag_err_q, tag_err_d;
  cnt_t        count_q, count_d;
  ptr_t        rptr_q, rptr_d;
  ptr_t        wptr_q, wptr_d;

  logic [31:0] pc_mem [FIFO_DEPTH];
  logic [31:0] ins_mem [FIFO_DEPTH];

  logic flush, issue, push, pop;
  cnt_t occ;

  logic unused_rpc;
  assign unused_rpc = ^redirect_pc_i[1:0];

  assign imem_pc_o   = pc_q;
  assign tag_err_o   = tag_err_q;
  assign dec_valid_o = (count_q != '0);
  assign dec_pc_o    = pc_mem[rptr_q];
  assign dec_instr_o = ins_mem[rptr_q];

  // Slots already promised to the in-flight response count as occupied.
  assign occ   = count_q + cnt_t'(inflight_q);
  assign flush = redirect_valid_i;
  assign issue = !flush && (occ < cnt_t'(FIFO_DEPTH));
  assign push  = inflight_q && !flush;
  assign pop   = dec_valid_o && dec_ready_i && !flush;

  always_comb begin
    pc_d       = pc_q;
    exp_pc_d   = exp_pc_q;
    inflight_d = 1'b0;
    count_d    = count_q;
    rptr_d     = rptr_q;
    wptr_d     = wptr_q;
    tag_err_d  = tag_err_q;
    if (inflight_q && (imem_pc_i != exp_pc_q)) begin
      tag_err_d = 1'b1;
    end
    if (flush) begin
      pc_d    = {redirect_pc_i[31:2], 2'b00};
      count_d = '0;
      rptr_d  = '0;
      wptr_d  = '0;
    end else begin
      if (issue) begin
        exp_pc_d   = pc_q;
        pc_d       = pc_q + 32'd4;
        inflight_d = 1'b1;
      end
      if (push) wptr_d = wptr_q + ptr_t'(1);
      if (pop)  rptr_d = rptr_q + ptr_t'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + cnt_t'(1);
        2'b01:   count_d = count_q - cnt_t'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      exp_pc_q   <= '0;
      inflight_q <= 1'b0;
      tag_err_q  <= 1'b0;
      count_q    <= '0;
      rptr_q     <= '0;
      wptr_q     <= '0;
    end else begin
      pc_q       <= pc_d;
      exp_pc_q   <= exp_pc_d;
      inflight_q <= inflight_d;
      tag_err_q  <= tag_err_d;
      count_q    <= count_d;
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
    end
  end

  // Entries carry the expected PC so a bad echo cannot corrupt the stream.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      pc_mem[wptr_q]  <= exp_pc_q;
      ins_mem[wptr_q] <= imem_instr_i;
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (reset)
    !(push && !pop && (count_q == cnt_t'(FIFO_DEPTH)))
  );

endmodule
